// File: rtl/jtkcpu_pkg.sv
// Shared KCPU definitions: interrupt FSM state encodings and the vector
// codes exchanged with the memory controller.
package jtkcpu_pkg;

    // Interrupt control unit states
    typedef enum logic [1:0] {
        ST_RSTV = 2'd0,     // fetching the reset vector
        ST_IDLE = 2'd1,     // normal execution
        ST_PUSH = 2'd2,     // pushing registers on the stack
        ST_VEC  = 2'd3      // loading PC from the interrupt vector
    } int_state_t;

    // Vector codes seen by the memory controller
    localparam logic [2:0] VEC_NONE = 3'd0;
    localparam logic [2:0] VEC_IRQ  = 3'd1;
    localparam logic [2:0] VEC_FIRQ = 3'd2;
    localparam logic [2:0] VEC_NMI  = 3'd3;
    localparam logic [2:0] VEC_RST  = 3'd4;

    // FIRQ is the fast interrupt: only PC and CC are stacked
    function automatic logic full_push(input logic [2:0] code);
        return code != VEC_FIRQ;
    endfunction

endpackage

// File: rtl/jtkcpu_intsync.sv
// Two-flop synchroniser for an active-low interrupt pin, with a registered
// copy of the synchronised level to flag a falling edge. All stages advance
// on cen and reset to the idle (high) level.
module jtkcpu_intsync (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic pin_n,
    output logic sync_n,
    output logic fall
);

    logic meta_n;
    logic last_n;

    // Synchroniser chain plus edge-history stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_n <= 1'b1;
            sync_n <= 1'b1;
            last_n <= 1'b1;
        end else if (cen) begin
            meta_n <= pin_n;
            sync_n <= meta_n;
            last_n <= sync_n;
        end
    end

    // High for one cen period after the synchronised level drops
    assign fall = last_n & ~sync_n;

endmodule

// File: rtl/jtkcpu_intctrl.sv
// KCPU interrupt control unit. Synchronises NMI/FIRQ/IRQ, arbitrates at
// instruction boundaries and sequences stack push and vector fetch.
// Build option: JTKCPU_NMI_ARM_EN -- NMI edges are discarded until the
// first nmi_arm pulse after reset (stack pointer initialised).
module jtkcpu_intctrl
    import jtkcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       nmi_n,
    input  logic       firq_n,
    input  logic       irq_n,
    input  logic       cc_i,
    input  logic       cc_f,
    input  logic       op_done,
    input  logic       psh_done,
    input  logic       vec_done,
    input  logic       nmi_arm,
    output logic       psh_req,
    output logic       psh_full,
    output logic [2:0] intvec,
    output logic       set_i,
    output logic       set_f,
    output logic       set_e,
    output logic       int_busy
);

    int_state_t state, nxt;
    logic [2:0] src, nxt_src;

    logic nmi_fall, nmi_lvl_unused;
    logic firq_lvl_n, firq_fall_unused;
    logic irq_lvl_n, irq_fall_unused;
    logic nmi_pend, nmi_armed;
    logic firq_pend, irq_pend;
    logic enter_push, enter_vec, nmi_take;

    jtkcpu_intsync u_nmi (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .pin_n  (nmi_n),
        .sync_n (nmi_lvl_unused),
        .fall   (nmi_fall)
    );

    jtkcpu_intsync u_firq (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .pin_n  (firq_n),
        .sync_n (firq_lvl_n),
        .fall   (firq_fall_unused)
    );

    jtkcpu_intsync u_irq (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .pin_n  (irq_n),
        .sync_n (irq_lvl_n),
        .fall   (irq_fall_unused)
    );

`ifdef JTKCPU_NMI_ARM_EN
    // NMI stays disarmed until software has set up the stack pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       nmi_armed <= 1'b0;
        else if (nmi_arm) nmi_armed <= 1'b1;
    end
`else
    logic unused_nmi_arm;
    assign unused_nmi_arm = nmi_arm;
    assign nmi_armed      = 1'b1;
`endif

    // FIRQ/IRQ are level requests gated by the CC masks
    assign firq_pend = ~firq_lvl_n & ~cc_f;
    assign irq_pend  = ~irq_lvl_n  & ~cc_i;

    // Next-state and source selection
    always_comb begin
        nxt     = state;
        nxt_src = src;
        case (state)
            ST_RSTV: if (vec_done) nxt = ST_IDLE;
            ST_IDLE: begin
                if (op_done) begin
                    if (nmi_pend) begin
                        nxt     = ST_PUSH;
                        nxt_src = VEC_NMI;
                    end else if (firq_pend) begin
                        nxt     = ST_PUSH;
                        nxt_src = VEC_FIRQ;
                    end else if (irq_pend) begin
                        nxt     = ST_PUSH;
                        nxt_src = VEC_IRQ;
                    end
                end
            end
            ST_PUSH: if (psh_done) nxt = ST_VEC;
            ST_VEC:  if (vec_done) nxt = ST_IDLE;
            default: nxt = ST_RSTV;
        endcase
    end

    assign enter_push = (state == ST_IDLE) && (nxt == ST_PUSH);
    assign enter_vec  = (state == ST_PUSH) && (nxt == ST_VEC);
    assign nmi_take   = enter_push && (nxt_src == VEC_NMI);

    // State and latched source; source is frozen once PUSH is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RSTV;
            src   <= VEC_NONE;
        end else if (cen) begin
            state <= nxt;
            src   <= nxt_src;
        end
    end

    // NMI edge latch; a fresh edge on the serving cycle wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_pend <= 1'b0;
        end else if (cen) begin
            if (nmi_take)              nmi_pend <= 1'b0;
            if (nmi_fall && nmi_armed) nmi_pend <= 1'b1;
        end
    end

    // One-cen pulses on PUSH and VEC entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psh_req <= 1'b0;
            set_e   <= 1'b0;
            set_i   <= 1'b0;
            set_f   <= 1'b0;
        end else if (cen) begin
            psh_req <= enter_push;
            set_e   <= enter_push && full_push(nxt_src);
            set_i   <= enter_vec;
            set_f   <= enter_vec && (src != VEC_IRQ);
        end
    end

    assign psh_full = (state == ST_PUSH) && full_push(src);
    assign int_busy = (state != ST_IDLE);
    assign intvec   = (state == ST_RSTV) ? VEC_RST :
                      (state == ST_VEC)  ? src     : VEC_NONE;

endmodule

// File: doc/jtkcpu_intctrl.md
JTKCPU_INTCTRL -- requirements
Module: jtkcpu_intctrl

Interface
REQ-001 SHALL have no parameters; the only compile-time option is the macro in Configuration.
REQ-002 SHALL have port clk  in  1  system clock, all flops on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port cen  in  1  clock enable of the control unit; state advances only when high.
REQ-005 SHALL have ports nmi_n, firq_n, irq_n  in  1 each  asynchronous interrupt pins, active low.
REQ-006 SHALL have ports cc_i, cc_f  in  1 each  IRQ/FIRQ mask bits from the condition-code register.
REQ-007 SHALL have port op_done  in  1  instruction boundary, one cen pulse.
REQ-008 SHALL have ports psh_done, vec_done  in  1 each  register push finished; PC loaded from vector (memory controller up_pc).
REQ-009 SHALL have port nmi_arm  in  1  stack pointer written; used only when the macro is defined.
REQ-010 SHALL have ports psh_req, psh_full  out  1 each  start register push; push all registers (else PC+CC only).
REQ-011 SHALL have port intvec  out  3  vector code to memory controller: 0 none, 1 IRQ, 2 FIRQ, 3 NMI, 4 RST.
REQ-012 SHALL have ports set_i, set_f, set_e  out  1 each  one-cen pulses that set CC I, F, E.
REQ-013 SHALL have port int_busy  out  1  high while any interrupt sequence is active; stalls instruction fetch.

Function
REQ-014 SHALL synchronise each pin through two flops clocked by clk, sampled on cen.
REQ-015 SHALL latch an NMI request on a synchronised falling edge of nmi_n; it is cleared only on entry to PUSH for NMI.
REQ-016 SHALL treat FIRQ and IRQ as levels: pending = pin low and mask bit clear.
REQ-017 SHALL implement states RSTV, IDLE, PUSH, VEC.
REQ-018 SHALL enter RSTV after reset: intvec=4, int_busy=1, no push; move to IDLE on vec_done.
REQ-019 SHALL, in IDLE, on op_done with a request pending, select by priority NMI > FIRQ > IRQ, latch it and go to PUSH; without op_done it stays in IDLE.
REQ-020 SHALL assert psh_req for exactly one cen cycle on PUSH entry, with psh_full=1 for NMI/IRQ and 0 for FIRQ held for the whole PUSH state, and set_e pulsing with psh_req when psh_full=1.
REQ-021 SHALL move from PUSH to VEC on psh_done, then drive intvec with the latched code until vec_done.
REQ-022 SHALL pulse on VEC entry: set_i and set_f for NMI and FIRQ; set_i only for IRQ.
REQ-023 SHALL return to IDLE on vec_done with intvec=0 the same cycle.
REQ-024 SHALL keep the latched source fixed once PUSH is entered; a higher-priority request arriving later is served after return to IDLE and the next op_done.
REQ-025 SHALL register an NMI edge arriving during PUSH/VEC; the edge is not lost.
REQ-026 SHALL ignore a FIRQ/IRQ that deasserts before op_done.
REQ-027 SHALL ignore psh_done and vec_done outside PUSH and VEC/RSTV respectively.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-sequence, immediately force state RSTV, clear the NMI latch and synchronisers to idle level (1), psh_req=psh_full=set_*=0, intvec=4, int_busy=1.

Configuration
REQ-029 SHALL, with JTKCPU_NMI_ARM_EN defined, discard NMI edges until the first nmi_arm pulse after reset; arming persists until reset.
REQ-030 SHALL, without JTKCPU_NMI_ARM_EN, accept NMI edges from reset release and ignore nmi_arm.

Structure
REQ-031 SHALL take the state encodings and intvec codes (NONE, IRQ, FIRQ, NMI, RST) from the shared package jtkcpu_pkg, which the memory controller also uses.
REQ-032 SHALL instantiate sub-module jtkcpu_intsync three times: a two-flop synchroniser with falling-edge output.

Verification
REQ-033 SHALL cover: release reset -> intvec=4 until vec_done, then 0, int_busy falls.
REQ-034 SHALL cover: irq_n low, cc_i=0, op_done -> psh_req pulse with psh_full=1, set_e; psh_done -> intvec=1, set_i.
REQ-035 SHALL cover: firq_n and irq_n low together, masks clear -> FIRQ served, psh_full=0, intvec=2, set_i and set_f.
REQ-036 SHALL cover: nmi_n edge during an IRQ PUSH -> IRQ completes, then next op_done gives intvec=3.
REQ-037 SHALL cover: irq_n low with cc_i=1 for 100 op_done pulses -> psh_req never asserts.
REQ-038 SHALL cover: rst_n low while in VEC -> intvec=4 and psh_req=0 immediately; with JTKCPU_NMI_ARM_EN an NMI edge before nmi_arm is ignored.
